// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_pkg
//  Description : Shared constants, scoring state encoding and peg helper for
//                the Mastermind control, datapath and scoring blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

    localparam int PEGS    = 4;
    localparam int COLOR_W = 3;
    localparam int CODE_W  = PEGS * COLOR_W;

    // Scoring sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXACT   = 3'd1,
        PARTIAL = 3'd2,
        REPORT  = 3'd3,
        OVER    = 3'd4
    } state_t;

    // Colour of peg 'idx' within a packed code word; peg 0 occupies the LSBs
    function automatic logic [COLOR_W-1:0] peg_at(input logic [CODE_W-1:0] word,
                                                  input logic [1:0]        idx);
        return word[int'(idx)*COLOR_W +: COLOR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mastermind_score_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_score_seq
//  Description : Multi-cycle Mastermind scorer. A single shared peg comparator
//                is stepped over 4 exact-position pairs and then 16 cross
//                pairs, producing black/white counts, a turn counter and
//                sticky win/lose flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module mastermind_score_seq
    import mastermind_pkg::*;
#(
    parameter int MAX_TURNS = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              new_game,
    input  logic [CODE_W-1:0] code,
    input  logic [CODE_W-1:0] guess,
    output logic              busy,
    output logic              done,
    output logic [2:0]        black,
    output logic [2:0]        white,
    output logic [3:0]        turn,
    output logic              win,
    output logic              lose
);

    localparam logic [3:0] c_max_turns = 4'(MAX_TURNS);

    state_t            r_state;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] r_guess;
    logic [3:0]        r_step;
    logic [3:0]        r_used_code;
    logic [3:0]        r_used_guess;
    logic [2:0]        r_black_w;
    logic [2:0]        r_white_w;
    logic              r_done;
    logic [2:0]        r_black;
    logic [2:0]        r_white;
    logic [3:0]        r_turn;
    logic              r_win;
    logic              r_lose;

    logic [1:0]        w_code_idx;
    logic [1:0]        w_guess_idx;
    logic              w_eq;
    logic              w_free;

    // Operand muxing for the shared comparator: the code peg always follows
    // the low step bits; the guess peg follows them in EXACT and the high
    // step bits in PARTIAL so all 16 guess/code pairs get visited.
    always_comb begin
        w_code_idx  = r_step[1:0];
        w_guess_idx = (r_state == PARTIAL) ? r_step[3:2] : r_step[1:0];
        w_eq        = (peg_at(r_code, w_code_idx) == peg_at(r_guess, w_guess_idx));
        w_free      = !r_used_guess[w_guess_idx] && !r_used_code[w_code_idx];
    end

    // Scoring FSM, working counters, masks and registered result outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_code       <= '0;
            r_guess      <= '0;
            r_step       <= '0;
            r_used_code  <= '0;
            r_used_guess <= '0;
            r_black_w    <= '0;
            r_white_w    <= '0;
            r_done       <= 1'b0;
            r_black      <= '0;
            r_white      <= '0;
            r_turn       <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else if (new_game) begin
            // A new game wins over everything, including a pending start
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_black <= '0;
            r_white <= '0;
            r_turn  <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_code       <= code;
                        r_guess      <= guess;
                        r_step       <= '0;
                        r_used_code  <= '0;
                        r_used_guess <= '0;
                        r_black_w    <= '0;
                        r_white_w    <= '0;
                        r_state      <= EXACT;
                    end
                end
                EXACT: begin
                    if (w_eq) begin
                        r_black_w                 <= r_black_w + 3'd1;
                        r_used_code[w_code_idx]   <= 1'b1;
                        r_used_guess[w_guess_idx] <= 1'b1;
                    end
                    if (r_step == 4'd3) begin
                        r_step  <= '0;
                        r_state <= PARTIAL;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                PARTIAL: begin
                    if (w_eq && w_free) begin
                        r_white_w                 <= r_white_w + 3'd1;
                        r_used_code[w_code_idx]   <= 1'b1;
                        r_used_guess[w_guess_idx] <= 1'b1;
                    end
                    if (r_step == 4'd15) begin
                        // Results are loaded on entry so they are visible
                        // during the REPORT cycle alongside done
                        r_state <= REPORT;
                        r_done  <= 1'b1;
                        r_black <= r_black_w;
                        r_white <= r_white_w + {2'b00, (w_eq && w_free)};
                        r_turn  <= r_turn + 4'd1;
                        if (r_black_w == 3'd4) begin
                            r_win <= 1'b1;
                        end else if (r_turn + 4'd1 == c_max_turns) begin
                            r_lose <= 1'b1;
                        end
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                REPORT: begin
                    r_done  <= 1'b0;
                    r_state <= (r_win || r_lose) ? OVER : IDLE;
                end
                OVER: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state == EXACT) || (r_state == PARTIAL) || (r_state == REPORT);
    assign done  = r_done;
    assign black = r_black;
    assign white = r_white;
    assign turn  = r_turn;
    assign win   = r_win;
    assign lose  = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_score_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mastermind_score_seq
//  Description : Self-checking bench for mastermind_score_seq with a
//                colour-count reference model of Mastermind scoring.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mastermind_score_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        new_game;
    logic [11:0] code;
    logic [11:0] guess;
    logic        busy;
    logic        done;
    logic [2:0]  black;
    logic [2:0]  white;
    logic [3:0]  turn;
    logic        win;
    logic        lose;

    int n_cmp = 0;
    int n_bad = 0;

    // Game-level model state
    int m_turn  = 0;
    int m_black = 0;
    int m_white = 0;
    bit m_win   = 0;
    bit m_lose  = 0;

    mastermind_score_seq #(.MAX_TURNS(10)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .new_game (new_game),
        .code     (code),
        .guess    (guess),
        .busy     (busy),
        .done     (done),
        .black    (black),
        .white    (white),
        .turn     (turn),
        .win      (win),
        .lose     (lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Black = same colour at same position; white = per-colour overlap minus black
    function automatic void ref_score(input logic [11:0] c, input logic [11:0] g,
                                      output int b, output int w);
        int cc[8];
        int gc[8];
        int total;
        logic [11:0] cw;
        logic [11:0] gw;
        cw = c;
        gw = g;
        b = 0;
        total = 0;
        for (int k = 0; k < 8; k++) begin
            cc[k] = 0;
            gc[k] = 0;
        end
        for (int p = 0; p < 4; p++) begin
            if (cw[3*p +: 3] == gw[3*p +: 3]) b++;
            cc[cw[3*p +: 3]]++;
            gc[gw[3*p +: 3]]++;
        end
        for (int k = 0; k < 8; k++) total += (cc[k] < gc[k]) ? cc[k] : gc[k];
        w = total - b;
    endfunction

    function automatic void model_clear();
        m_turn  = 0;
        m_black = 0;
        m_white = 0;
        m_win   = 0;
        m_lose  = 0;
    endfunction

    // Pulse start, scramble the inputs after capture, and check the result
    // (or that nothing happens once the game is over)
    task automatic score(input logic [11:0] c, input logic [11:0] g, input string tag);
        int lat;
        int b;
        int w;
        bit over;
        logic [2:0] s_black;
        logic [2:0] s_white;
        logic [3:0] s_turn;
        logic       s_win;
        logic       s_lose;
        over = m_win || m_lose;
        lat = 0;
        s_black = '0; s_white = '0; s_turn = '0; s_win = 1'b0; s_lose = 1'b0;
        code  = c;
        guess = g;
        start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 2) begin
                code  = ~c;
                guess = 12'($urandom);
            end
            if (n == 1) check({tag, ".busy"}, 32'(busy), over ? 32'd0 : 32'd1);
            if (done && lat == 0) begin
                lat = n;
                s_black = black; s_white = white; s_turn = turn; s_win = win; s_lose = lose;
            end
        end
        if (over) begin
            check({tag, ".ignored"}, 32'(lat), 32'd0);
        end else begin
            ref_score(c, g, b, w);
            m_black = b;
            m_white = w;
            m_turn++;
            if (b == 4) m_win = 1;
            else if (m_turn == 10) m_lose = 1;
            check({tag, ".latency"}, 32'(lat), 32'd21);
            check({tag, ".black"}, 32'(s_black), 32'(m_black));
            check({tag, ".white"}, 32'(s_white), 32'(m_white));
            check({tag, ".turn"}, 32'(s_turn), 32'(m_turn));
            check({tag, ".win"}, 32'(s_win), 32'(m_win));
            check({tag, ".lose"}, 32'(s_lose), 32'(m_lose));
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    initial begin
        int seen_done;
        resetn   = 1'b0;
        start    = 1'b0;
        new_game = 1'b0;
        code     = '0;
        guess    = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.black", 32'(black), 32'd0);
        check("rst.white", 32'(white), 32'd0);
        check("rst.turn", 32'(turn), 32'd0);
        check("rst.win", 32'(win), 32'd0);
        check("rst.lose", 32'(lose), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Exact win, then start is ignored in OVER
        score(12'h8D1, 12'h8D1, "win");
        score(12'h8D1, 12'h8D1, "over");
        pulse_new_game();
        check("ng.turn", 32'(turn), 32'd0);
        check("ng.win", 32'(win), 32'd0);

        // All white, duplicates
        score(12'h8D1, 12'h29C, "allwhite");
        score(12'h489, 12'hA51, "dups");

        // Random guesses against random codes
        pulse_new_game();
        for (int r = 0; r < 8; r++) begin
            logic [11:0] rc;
            logic [11:0] rg;
            rc = 12'($urandom);
            rg = ($urandom_range(0, 3) == 0) ? rc : 12'($urandom);
            if (r == 1) rg = {rc[2:0], rc[11:3]};
            score(rc, rg, "rand");
            if (m_win || m_lose) pulse_new_game();
        end

        // Lose after ten misses, then start ignored
        pulse_new_game();
        for (int t = 0; t < 10; t++) score(12'h8D1, 12'hFFF, "lose");
        check("lose.turn", 32'(turn), 32'd10);
        check("lose.flag", 32'(lose), 32'd1);
        check("lose.win", 32'(win), 32'd0);
        score(12'h8D1, 12'h8D1, "lose.over");

        // Abort mid-scoring with new_game
        pulse_new_game();
        score(12'h8D1, 12'h8D1 ^ 12'h007, "pre_abort");
        code  = 12'h8D1;
        guess = 12'h8D1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check("abort.busy", 32'(busy), 32'd0);
        seen_done = 0;
        for (int n = 0; n < 25; n++) begin
            if (done) seen_done = 1;
            @(negedge clk);
        end
        check("abort.nodone", 32'(seen_done), 32'd0);
        check("abort.turn", 32'(turn), 32'd0);
        check("abort.black", 32'(black), 32'd0);
        check("abort.white", 32'(white), 32'd0);

        // start together with new_game stays idle
        start    = 1'b1;
        new_game = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        new_game = 1'b0;
        check("prio.busy", 32'(busy), 32'd0);

        // Async reset mid-PARTIAL clears outputs without a clock edge
        score(12'h8D1, 12'h29C, "pre_rst");
        code  = 12'h123;
        guess = 12'h321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.turn", 32'(turn), 32'd0);
        check("arst.white", 32'(white), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        model_clear();
        @(negedge clk);
        score(12'h489, 12'hA51, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
